// File: rtl/rs232_des_cfg.sv
// rtl/rs232_des_cfg.sv - RS-232 receive deserializer, configurable data/parity/stop framing
// Glitch-rejecting start detection, parity/framing flags, break and overrun reporting.
module rs232_des_cfg #(
    parameter int P_CLK_FREQ_HZ = 100000000,
    parameter int P_BAUD_RATE   = 9600,
    parameter int P_DATA_BITS   = 8,
    parameter int P_PARITY      = 0,
    parameter int P_STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_fifo_data,
    output logic       rx_fifo_perr,
    output logic       rx_fifo_ferr,
    output logic       rx_fifo_wr_en,
    input  logic       rx_fifo_full,
    output logic       rx_overrun,
    output logic       rx_break
);
    localparam int DIV = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t        state_q, state_d;
    logic          rx_m, rx_s, rx_prev;
    logic [1:0]    warm;
    logic          armed;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit, stop0, ferr_acc;

    logic          half_hit, full_hit, step, cnt_clr;
    logic          do_write, do_ovr, do_brk;
    logic          first_stop, frame_perr, frame_ferr;
    logic [7:0]    frame_data;

    // armed only after the synchronizer holds a real line sample that is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            warm    <= 2'd0;
            armed   <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            if (warm != 2'd2) warm <= warm + 2'd1;
            if (warm == 2'd2 && rx_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        do_write   = 1'b0;
        do_ovr     = 1'b0;
        do_brk     = 1'b0;
        half_hit   = (bit_cnt == HALF_M1);
        full_hit   = (bit_cnt == FULL_M1);
        step       = full_hit && (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP);
        first_stop = (bit_idx == 3'd0) ? rx_s : stop0;
        frame_data = shreg >> (8 - P_DATA_BITS);
        frame_perr = (P_PARITY == 0) ? 1'b0 : ((^shreg ^ par_bit) != (P_PARITY == 2));
        frame_ferr = ferr_acc | ~rx_s;
        case (state_q)
            S_IDLE:   if (armed && rx_prev && !rx_s) state_d = S_START;
            S_START:  if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (full_hit && bit_idx == 3'(P_DATA_BITS - 1))
                          state_d = (P_PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (full_hit) state_d = S_STOP;
            S_STOP: begin
                if (full_hit && bit_idx == 3'(P_STOP_BITS - 1)) begin
                    if (shreg == 8'd0 && (P_PARITY == 0 || !par_bit) && !first_stop) begin
                        do_brk  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        do_write = !rx_fifo_full;
                        do_ovr   = rx_fifo_full;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_BREAK:  if (rx_s) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        cnt_clr = (state_d != state_q) || step || state_q == S_IDLE || state_q == S_BREAK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            par_bit  <= 1'b0;
            stop0    <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
            if (state_d != state_q) bit_idx <= 3'd0;
            else if (step)          bit_idx <= bit_idx + 3'd1;
            if (state_q == S_IDLE) begin
                shreg    <= 8'd0;
                ferr_acc <= 1'b0;
            end
            if (state_q == S_DATA && full_hit) shreg <= {rx_s, shreg[7:1]};
            if (state_q == S_PARITY && full_hit) par_bit <= rx_s;
            if (state_q == S_STOP && full_hit) begin
                if (bit_idx == 3'd0) stop0 <= rx_s;
                if (!rx_s) ferr_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_fifo_data  <= 8'd0;
            rx_fifo_perr  <= 1'b0;
            rx_fifo_ferr  <= 1'b0;
            rx_fifo_wr_en <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_break      <= 1'b0;
        end else begin
            rx_fifo_wr_en <= do_write;
            rx_overrun    <= do_ovr;
            rx_break      <= do_brk;
            if (do_write) begin
                rx_fifo_data <= frame_data;
                rx_fifo_perr <= frame_perr;
                rx_fifo_ferr <= frame_ferr;
            end
        end
    end
endmodule

// File: tb/tb_rs232_des_cfg.sv
// tb/tb_rs232_des_cfg.sv - directed bench for rs232_des_cfg in 8N1, 7E1 and 8O2 framings
module tb_rs232_des_cfg;
    localparam int DIV = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx_v;
    logic [2:0] full;
    logic [7:0] d0, d1, d2;
    logic [2:0] we, pe, fe, ov, bk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int wr_cnt[3], ovr_cnt[3], brk_cnt[3], wr_cyc[3];
    logic [7:0] q_data[$];
    logic [1:0] q_err[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs232_des_cfg #(.P_CLK_FREQ_HZ(100000000), .P_BAUD_RATE(1000000), .P_DATA_BITS(8),
                    .P_PARITY(0), .P_STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .rx_fifo_data(d0), .rx_fifo_perr(pe[0]),
        .rx_fifo_ferr(fe[0]), .rx_fifo_wr_en(we[0]), .rx_fifo_full(full[0]),
        .rx_overrun(ov[0]), .rx_break(bk[0]));

    rs232_des_cfg #(.P_CLK_FREQ_HZ(100000000), .P_BAUD_RATE(1000000), .P_DATA_BITS(7),
                    .P_PARITY(1), .P_STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .rx_fifo_data(d1), .rx_fifo_perr(pe[1]),
        .rx_fifo_ferr(fe[1]), .rx_fifo_wr_en(we[1]), .rx_fifo_full(full[1]),
        .rx_overrun(ov[1]), .rx_break(bk[1]));

    rs232_des_cfg #(.P_CLK_FREQ_HZ(100000000), .P_BAUD_RATE(1000000), .P_DATA_BITS(8),
                    .P_PARITY(2), .P_STOP_BITS(2)) u_8o2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .rx_fifo_data(d2), .rx_fifo_perr(pe[2]),
        .rx_fifo_ferr(fe[2]), .rx_fifo_wr_en(we[2]), .rx_fifo_full(full[2]),
        .rx_overrun(ov[2]), .rx_break(bk[2]));

    initial begin
        for (int i = 0; i < 3; i++) begin
            wr_cnt[i] = 0; ovr_cnt[i] = 0; brk_cnt[i] = 0; wr_cyc[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i]) begin
                wr_cnt[i] = wr_cnt[i] + 1;
                wr_cyc[i] = cyc;
            end
            if (ov[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
            if (bk[i]) brk_cnt[i] = brk_cnt[i] + 1;
        end
        if (we[2]) begin
            q_data.push_back(d2);
            q_err.push_back({pe[2], fe[2]});
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int sel, input logic b);
        rx_v[sel] = b;
        idle(DIV);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                              input int pmode, input logic pflip, input int nstop,
                              input logic stop_low);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        if (pmode == 2) p = ~p;
        fall_cyc = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
        if (pmode != 0) drive_bit(sel, p ^ pflip);
        for (int i = 0; i < nstop; i++) drive_bit(sel, ~stop_low);
        rx_v[sel] = 1'b1;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        rx_v  = 3'b111;
        full  = 3'b000;
        idle(5);
        check("rst_data", d0, 8'h00);
        check("rst_strobes", {we, ov, bk}, 9'd0);
        check("rst_flags", {pe, fe}, 6'd0);
        rst_n = 1'b1;
        idle(20);

        // 8N1 0xA5 and its latency
        send_frame(0, 8'hA5, 8, 0, 1'b0, 1, 1'b0);
        idle(50);
        check("t1_wr_cnt", wr_cnt[0], 1);
        check("t1_data", d0, 8'hA5);
        check("t1_flags", {pe[0], fe[0]}, 2'b00);
        lat = wr_cyc[0] - fall_cyc;
        check("t1_latency_950_956", (lat >= 950 && lat <= 956) ? 1 : 0, 1);

        // 7E1 good and bad parity
        send_frame(1, 8'h41, 7, 1, 1'b0, 1, 1'b0);
        idle(50);
        check("t2_wr_cnt", wr_cnt[1], 1);
        check("t2_data", d1, 8'h41);
        check("t2_perr", pe[1], 0);
        send_frame(1, 8'h41, 7, 1, 1'b1, 1, 1'b0);
        idle(50);
        check("t2b_wr_cnt", wr_cnt[1], 2);
        check("t2b_data", d1, 8'h41);
        check("t2b_perr", pe[1], 1);

        // start glitch then a good frame
        rx_v[0] = 1'b0;
        idle(30);
        rx_v[0] = 1'b1;
        idle(1200);
        check("t3_no_wr", wr_cnt[0], 1);
        check("t3_no_brk", brk_cnt[0], 0);
        check("t3_idle", u_8n1.state_q, 0);
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1, 1'b0);
        idle(50);
        check("t3_wr_cnt", wr_cnt[0], 2);
        check("t3_data", d0, 8'h3C);

        // framing error, then break
        send_frame(0, 8'h55, 8, 0, 1'b0, 1, 1'b1);
        idle(50);
        check("t4_wr_cnt", wr_cnt[0], 3);
        check("t4_data", d0, 8'h55);
        check("t4_ferr", fe[0], 1);
        rx_v[0] = 1'b0;
        idle(12 * DIV);
        rx_v[0] = 1'b1;
        idle(300);
        check("t4_brk_cnt", brk_cnt[0], 1);
        check("t4_brk_no_wr", wr_cnt[0], 3);
        check("t4_hold_data", d0, 8'h55);
        send_frame(0, 8'h12, 8, 0, 1'b0, 1, 1'b0);
        idle(50);
        check("t4b_wr_cnt", wr_cnt[0], 4);
        check("t4b_data", d0, 8'h12);
        check("t4b_ferr", fe[0], 0);

        // overrun, then back-to-back 8O2
        full[2] = 1'b1;
        send_frame(2, 8'h77, 8, 2, 1'b0, 2, 1'b0);
        idle(50);
        full[2] = 1'b0;
        check("t5_ovr_cnt", ovr_cnt[2], 1);
        check("t5_ovr_no_wr", wr_cnt[2], 0);
        q_data.delete();
        q_err.delete();
        send_frame(2, 8'h00, 8, 2, 1'b0, 2, 1'b0);
        send_frame(2, 8'hFF, 8, 2, 1'b0, 2, 1'b0);
        send_frame(2, 8'h80, 8, 2, 1'b0, 2, 1'b0);
        idle(100);
        check("t5_wr_cnt", wr_cnt[2], 3);
        check("t5_q_size", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("t5_data0", q_data[0], 8'h00);
            check("t5_data1", q_data[1], 8'hFF);
            check("t5_data2", q_data[2], 8'h80);
            check("t5_errs", {q_err[0], q_err[1], q_err[2]}, 6'd0);
        end
        check("t5_brk_none", brk_cnt[2], 0);

        // reset mid-frame, release with the line held low
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rst_n   = 1'b0;
        rx_v[0] = 1'b0;
        idle(10);
        check("t6_rst_data", d0, 8'h00);
        check("t6_rst_flags", {we[0], fe[0], pe[0], ov[0], bk[0]}, 5'd0);
        rst_n = 1'b1;
        idle(15 * DIV);
        check("t6_low_no_wr", wr_cnt[0], 4);
        check("t6_low_no_brk", brk_cnt[0], 1);
        rx_v[0] = 1'b1;
        idle(200);
        send_frame(0, 8'h99, 8, 0, 1'b0, 1, 1'b0);
        idle(50);
        check("t6_wr_cnt", wr_cnt[0], 5);
        check("t6_data", d0, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
